inst_decode_stage: RTL
======================

# inst_decode_stage

Registered instruction decode stage that assembles instructions from a narrow fetch bus, splits them into operand, immediate and type fields, and presents them to execute over a valid/ready handshake. It sits between the fetch byte stream and the execute unit. It generalises the combinational field splitter to parametric instruction, fetch, register-address and immediate widths. It adds multi-beat assembly, output buffering and pipeline flush.

## Interface
- `INST_W`, 16, instruction width; must be a multiple of `FETCH_W`.
- `FETCH_W`, 8, fetch beat width.
- `REG_ADDR_W`, 3, register address width.
- `IMM_W`, 8, immediate width; requires `INST_W-5-REG_ADDR_W >= IMM_W`.
- `clk_in`  in  1  clock.
- `rst_in`  in  1  reset; **asynchronous, active-high**.
- `beat_in`  in  FETCH_W  fetch beat.
- `beat_valid_in`  in  1  beat present.
- `beat_ready_out`  out  1  beat accepted when valid && ready.
- `flush_in`  in  1  discard partial assembly and held output.
- `src_addr_out`  out  REG_ADDR_W  `inst[INST_W-6 -: REG_ADDR_W]`.
- `dst_addr_out`  out  REG_ADDR_W  `inst[IMM_W-1 -: REG_ADDR_W]`.
- `imm_out`  out  IMM_W  `inst[IMM_W-1:0]`.
- `imm_type_out`  out  2  `inst[INST_W-4:INST_W-5]`.
- `cond_en_out`  out  1  `inst[INST_W-3]`.
- `inst_type_out`  out  2  `inst[INST_W-1:INST_W-2]`.
- `subtype_flag_out`  out  4  `inst[3:0]`.
- `dec_valid_out`  out  1  decoded fields valid.
- `dec_ready_in`  in  1  execute consumes when valid && ready.
- `dec_count_out`  out  16  decoded-instruction count; present only with `INST_DEC_PERF_CNT_EN`.

## Operation
- The beat count is `BEATS = INST_W/FETCH_W`. Beats arrive least-significant first. Beat k fills `inst[k*FETCH_W +: FETCH_W]`.
- The beat counter `beat_idx` runs from 0 to BEATS-1. It wraps to 0 after the last beat is accepted.
- `beat_ready_out = !flush_in && (beat_idx != BEATS-1 || !dec_valid_out || dec_ready_in)`.
  - Non-final beats are always accepted.
  - The final beat is accepted only if the output register is empty or is draining this cycle.
- On final-beat acceptance, the complete instruction is loaded into the output register and `dec_valid_out` is set. All field outputs are driven combinationally from that register.
- Output handshake:
  - Fields are held stable while `dec_valid_out && !dec_ready_in`.
  - On consume with no new load, `dec_valid_out` clears.
  - On consume with a simultaneous load, `dec_valid_out` stays 1 and the new fields appear.
- Flush:
  - `flush_in` clears `beat_idx` and `dec_valid_out`.
  - It wins over any same-cycle beat or consume; no beat is accepted that cycle.
  - A consume during a flush cycle does not count.
- BEATS = 1 is legal: the block degenerates to a registered decoder with the same handshake.
- Reset values: `beat_idx`=0, `dec_valid_out`=0, instruction register=0 (so all field outputs are 0), `dec_count_out`=0. Reset may assert mid-assembly; the partial instruction is discarded.

## Timing
- Latency: final beat accepted at edge N, so `dec_valid_out`=1 and valid fields appear after edge N.
- Throughput: one instruction per BEATS cycles with `dec_ready_in` held high; no bubbles.
- Backpressure stalls only the final beat. Earlier beats of the next instruction still fill.
- No combinational path from `beat_valid_in` to any output.
- `beat_ready_out` depends combinationally on `dec_ready_in` and `flush_in`.

## Configuration
- `INST_DEC_PERF_CNT_EN` defined:
  - `dec_count_out` increments by 1 on each consume (`dec_valid_out && dec_ready_in && !flush_in`).
  - It saturates at 0xFFFF and resets to 0.
- Undefined: the port and counter are absent, and the block's behaviour is otherwise identical.

## Structure
- Shared package `inst_pkg` holds:
  - `inst_type_e` (2-bit enum);
  - `imm_type_e` (2-bit enum);
  - field-offset localparams derived from `INST_W`/`IMM_W`/`REG_ADDR_W`;
  - a `dec_fields_t` packed struct.
- One sub-module is natural: `inst_field_split`, a purely combinational instruction-to-`dec_fields_t` slicer. The stage instantiates it on the output register.

## Test plan
- Beats 0xC3 then 0xA5, `dec_ready_in`=1: one cycle after the second beat, `inst_type_out`=2, `cond_en_out`=1, `imm_type_out`=0, `src_addr_out`=5, `dst_addr_out`=6, `imm_out`=0xC3, `subtype_flag_out`=3.
- Continuous beats for 4 instructions, ready held high: `dec_valid_out` pulses every 2 cycles with no gaps; count=4 (if `INST_DEC_PERF_CNT_EN`).
- Output held, `dec_ready_in`=0, next instruction streaming: first beat accepted, `beat_ready_out`=0 on second beat and fields unchanged. Raise ready: the consume and new load happen on the same edge, and `dec_valid_out` stays 1.
- `flush_in` on the cycle after the first beat 0x11, then beats 0x22, 0x33: decoded `imm_out`=0x22 (beat 0x11 discarded).
- Flush while output valid, with the final beat and ready asserted: `dec_valid_out`=0 next cycle, and beat not accepted.
- Reset asserted asynchronously mid-assembly: all outputs 0 immediately. After release, two fresh beats decode correctly.

Source files
------------

// File: rtl/inst_pkg.sv
// rtl/inst_pkg.sv - shared types, widths and field offsets for the instruction decode stage
package inst_pkg;

   localparam int INST_W_DEF     = 16;
   localparam int FETCH_W_DEF    = 8;
   localparam int REG_ADDR_W_DEF = 3;
   localparam int IMM_W_DEF      = 8;
   localparam int SUBTYPE_W      = 4;

   // Field offsets at the default widths; the splitter re-derives them from its own parameters.
   localparam int INST_TYPE_LSB = INST_W_DEF - 2;
   localparam int COND_EN_BIT   = INST_W_DEF - 3;
   localparam int IMM_TYPE_LSB  = INST_W_DEF - 5;
   localparam int SRC_ADDR_MSB  = INST_W_DEF - 6;
   localparam int DST_ADDR_MSB  = IMM_W_DEF - 1;

   typedef enum logic [1:0] {
      INST_ALU    = 2'd0,
      INST_MEM    = 2'd1,
      INST_BRANCH = 2'd2,
      INST_SYS    = 2'd3
   } inst_type_e;

   typedef enum logic [1:0] {
      IMM_NONE = 2'd0,
      IMM_ZEXT = 2'd1,
      IMM_SEXT = 2'd2,
      IMM_REL  = 2'd3
   } imm_type_e;

   // Register and immediate fields are sized at the default widths, which act as the ceiling.
   typedef struct packed {
      inst_type_e                  inst_type;
      logic                        cond_en;
      imm_type_e                   imm_type;
      logic [REG_ADDR_W_DEF-1:0]   src_addr;
      logic [REG_ADDR_W_DEF-1:0]   dst_addr;
      logic [IMM_W_DEF-1:0]        imm;
      logic [SUBTYPE_W-1:0]        subtype;
   } dec_fields_t;

endpackage

// File: rtl/inst_field_split.sv
// rtl/inst_field_split.sv - combinational slicer from a raw instruction word to dec_fields_t
module inst_field_split
   import inst_pkg::*;
#(
   parameter int INST_W     = INST_W_DEF,
   parameter int REG_ADDR_W = REG_ADDR_W_DEF,
   parameter int IMM_W      = IMM_W_DEF
) (
   input  logic [INST_W-1:0] inst,
   output dec_fields_t       fields
);

   always_comb begin
      fields           = '0;
      fields.inst_type = inst_type_e'(inst[INST_W-1 -: 2]);
      fields.cond_en   = inst[INST_W-3];
      fields.imm_type  = imm_type_e'(inst[INST_W-4 -: 2]);
      fields.src_addr  = REG_ADDR_W_DEF'(inst[INST_W-6 -: REG_ADDR_W]);
      fields.dst_addr  = REG_ADDR_W_DEF'(inst[IMM_W-1 -: REG_ADDR_W]);
      fields.imm       = IMM_W_DEF'(inst[IMM_W-1:0]);
      fields.subtype   = inst[SUBTYPE_W-1:0];
   end

endmodule

// File: rtl/inst_decode_stage.sv
// rtl/inst_decode_stage.sv - multi-beat instruction assembly and registered decode; INST_DEC_PERF_CNT_EN adds dec_count_out
module inst_decode_stage
   import inst_pkg::*;
#(
   parameter int INST_W     = INST_W_DEF,
   parameter int FETCH_W    = FETCH_W_DEF,
   parameter int REG_ADDR_W = REG_ADDR_W_DEF,
   parameter int IMM_W      = IMM_W_DEF
) (
   input  logic                  clk_in,
   input  logic                  rst_in,
   input  logic [FETCH_W-1:0]    beat_in,
   input  logic                  beat_valid_in,
   output logic                  beat_ready_out,
   input  logic                  flush_in,
   output logic [REG_ADDR_W-1:0] src_addr_out,
   output logic [REG_ADDR_W-1:0] dst_addr_out,
   output logic [IMM_W-1:0]      imm_out,
   output logic [1:0]            imm_type_out,
   output logic                  cond_en_out,
   output logic [1:0]            inst_type_out,
   output logic [3:0]            subtype_flag_out,
   output logic                  dec_valid_out,
`ifdef INST_DEC_PERF_CNT_EN
   output logic [15:0]           dec_count_out,
`endif
   input  logic                  dec_ready_in
);

   localparam int BEATS = INST_W / FETCH_W;
   localparam int IDX_W = (BEATS > 1) ? $clog2(BEATS) : 1;

   logic [IDX_W-1:0]  beat_idx;
   logic [INST_W-1:0] inst_buf;
   logic [INST_W-1:0] inst_reg;
   logic [INST_W-1:0] assembled;
   logic              last_beat;
   logic              accept;
   logic              consume;
   dec_fields_t       fields;

   assign last_beat      = (beat_idx == IDX_W'(BEATS - 1));
   assign beat_ready_out = !flush_in && (!last_beat || !dec_valid_out || dec_ready_in);
   assign accept         = beat_valid_in && beat_ready_out;
   assign consume        = dec_valid_out && dec_ready_in && !flush_in;

   // Partial word with the current beat merged in; on the final beat this is the whole instruction.
   always_comb begin
      assembled = inst_buf;
      assembled[beat_idx*FETCH_W +: FETCH_W] = beat_in;
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         beat_idx      <= '0;
         inst_buf      <= '0;
         inst_reg      <= '0;
         dec_valid_out <= 1'b0;
      end else if (flush_in) begin
         beat_idx      <= '0;
         dec_valid_out <= 1'b0;
      end else begin
         if (consume)
            dec_valid_out <= 1'b0;
         if (accept) begin
            inst_buf <= assembled;
            if (last_beat) begin
               beat_idx      <= '0;
               inst_reg      <= assembled;
               dec_valid_out <= 1'b1;
            end else begin
               beat_idx <= beat_idx + 1'b1;
            end
         end
      end
   end

`ifdef INST_DEC_PERF_CNT_EN
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in)
         dec_count_out <= '0;
      else if (consume && dec_count_out != 16'hFFFF)
         dec_count_out <= dec_count_out + 16'd1;
   end
`endif

   inst_field_split #(
      .INST_W     (INST_W),
      .REG_ADDR_W (REG_ADDR_W),
      .IMM_W      (IMM_W)
   ) u_split (
      .inst   (inst_reg),
      .fields (fields)
   );

   assign inst_type_out    = fields.inst_type;
   assign cond_en_out      = fields.cond_en;
   assign imm_type_out     = fields.imm_type;
   assign src_addr_out     = REG_ADDR_W'(fields.src_addr);
   assign dst_addr_out     = REG_ADDR_W'(fields.dst_addr);
   assign imm_out          = IMM_W'(fields.imm);
   assign subtype_flag_out = fields.subtype;

endmodule
